// File: rtl/board_lock_clear.sv
// Playfield store for the falling-block game.
//
// A lock pulse captures the four square coordinates and the piece colour, and writes
// them into a ROWS x COLS colour board. The board is then scanned bottom-up for full
// rows. Each full row is removed by shifting every row above it down by one. The line
// and score counters are updated at the end of the sequence. A registered read port
// serves the draw stage on every cycle, including while a sequence is running.
//
// Ports
//   pclk                  clock
//   rst                   asynchronous active-low reset
//   lock_en               1-cycle lock request; accepted only when idle
//   sq_N_col / sq_N_row   coordinates of the four squares (N = 1..4)
//   block                 piece code; colour = block[2:0] + 1
//   rd_row / rd_col       draw read address
//   rd_cell               registered cell colour; 0 for an out-of-range address
//   busy                  high while a lock sequence is in progress
//   clear_done            1-cycle pulse in the first idle cycle after a sequence;
//                         the counters below are already updated in that cycle
//   lines_last            rows cleared by the last lock (0..4)
//   lines_total           saturating total of cleared rows
//   score                 saturating score
//   game_over             sticky; set when a square is written into row 0
module board_lock_clear #(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned COLS    = 10,
  parameter int unsigned COLOR_W = 3
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               lock_en,
  input  logic [4:0]         sq_1_col,
  input  logic [4:0]         sq_2_col,
  input  logic [4:0]         sq_3_col,
  input  logic [4:0]         sq_4_col,
  input  logic [4:0]         sq_1_row,
  input  logic [4:0]         sq_2_row,
  input  logic [4:0]         sq_3_row,
  input  logic [4:0]         sq_4_row,
  input  logic [4:0]         block,
  input  logic [4:0]         rd_row,
  input  logic [4:0]         rd_col,
  output logic [COLOR_W-1:0] rd_cell,
  output logic               busy,
  output logic               clear_done,
  output logic [2:0]         lines_last,
  output logic [7:0]         lines_total,
  output logic [15:0]        score,
  output logic               game_over
);

  typedef enum logic [2:0] {StIdle, StWrite, StScan, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [4:0]           ptr_q, ptr_d;       // scan pointer
  logic [4:0]           sft_q, sft_d;       // shift pointer
  logic [2:0]           cnt_q, cnt_d;       // rows cleared in this sequence
  logic [4:0]           sq_col_q [4];
  logic [4:0]           sq_row_q [4];
  logic [COLOR_W-1:0]   color_q;
  logic [COLOR_W-1:0]   board_q [ROWS][COLS];
  logic [COLOR_W-1:0]   board_d [ROWS][COLS];
  logic [COLOR_W-1:0]   rd_cell_q, rd_cell_d;
  logic                 clear_done_q, clear_done_d;
  logic [2:0]           lines_last_q, lines_last_d;
  logic [7:0]           lines_total_q, lines_total_d;
  logic [15:0]          score_q, score_d;
  logic                 game_over_q, game_over_d;

  logic [ROWS-1:0]      row_full;
  logic                 ptr_full;
  logic                 go_hit;
  logic [15:0]          score_add;
  logic [16:0]          score_sum;
  logic [8:0]           lines_sum;
  logic                 unused_block;

  // Only the low bits of the piece code select the colour.
  assign unused_block = ^block[4:3];

  // ---------------------------------------------------------------------------
  // Row status
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_full[r] = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        if (board_q[r][c] == '0) row_full[r] = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (ptr_q == 5'(r)) ptr_full = row_full[r];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sft_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sft_q   <= sft_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sft_d   = sft_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lock_en) state_d = StWrite;
      end
      StWrite: begin
        state_d = StScan;
        ptr_d   = 5'(ROWS - 1);
      end
      StScan: begin
        if (ptr_full) begin
          state_d = StShift;
          sft_d   = ptr_q;
          cnt_d   = cnt_q + 3'd1;
        end else if (ptr_q != 5'd0) begin
          ptr_d = ptr_q - 5'd1;
        end else begin
          state_d = StDone;
        end
      end
      StShift: begin
        // The pointer stays put after the shift so the row moved in gets rescanned.
        if (sft_q != 5'd0) sft_d = sft_q - 5'd1;
        else               state_d = StScan;
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Piece capture; squares are held so the write does not depend on the inputs
  // staying stable after the lock pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        sq_col_q[k] <= '0;
        sq_row_q[k] <= '0;
      end
      color_q <= '0;
    end else if (state_q == StIdle && lock_en) begin
      sq_col_q[0] <= sq_1_col;
      sq_col_q[1] <= sq_2_col;
      sq_col_q[2] <= sq_3_col;
      sq_col_q[3] <= sq_4_col;
      sq_row_q[0] <= sq_1_row;
      sq_row_q[1] <= sq_2_row;
      sq_row_q[2] <= sq_3_row;
      sq_row_q[3] <= sq_4_row;
      color_q     <= COLOR_W'({1'b0, block[2:0]} + 4'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Board write and shift
  // ---------------------------------------------------------------------------
  always_comb begin
    board_d = board_q;
    if (state_q == StWrite) begin
      // Out-of-range coordinates never match a cell, so they are skipped naturally.
      for (int k = 0; k < 4; k++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (sq_row_q[k] == 5'(r) && sq_col_q[k] == 5'(c)) board_d[r][c] = color_q;
          end
        end
      end
    end
    if (state_q == StShift) begin
      for (int r = 1; r < ROWS; r++) begin
        if (sft_q == 5'(r)) board_d[r] = board_q[r-1];
      end
      if (sft_q == 5'd0) begin
        for (int c = 0; c < COLS; c++) board_d[0][c] = '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) board_q[r][c] <= '0;
      end
    end else begin
      board_q <= board_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and status
  // ---------------------------------------------------------------------------
  always_comb begin
    go_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sq_row_q[k] == 5'd0 && sq_col_q[k] < 5'(COLS)) go_hit = 1'b1;
    end
  end

  always_comb begin
    case (cnt_q)
      3'd1:    score_add = 16'd40;
      3'd2:    score_add = 16'd100;
      3'd3:    score_add = 16'd300;
      3'd4:    score_add = 16'd1200;
      default: score_add = 16'd0;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {1'b0, score_add};
  assign lines_sum = {1'b0, lines_total_q} + 9'(cnt_q);

  always_comb begin
    lines_last_d  = lines_last_q;
    lines_total_d = lines_total_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    clear_done_d  = 1'b0;
    if (state_q == StWrite && go_hit) game_over_d = 1'b1;
    if (state_q == StDone) begin
      clear_done_d  = 1'b1;
      lines_last_d  = cnt_q;
      lines_total_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
      score_d       = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // Read port
  always_comb begin
    rd_cell_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_row == 5'(r) && rd_col == 5'(c)) rd_cell_d = board_q[r][c];
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rd_cell_q     <= '0;
      clear_done_q  <= 1'b0;
      lines_last_q  <= '0;
      lines_total_q <= '0;
      score_q       <= '0;
      game_over_q   <= 1'b0;
    end else begin
      rd_cell_q     <= rd_cell_d;
      clear_done_q  <= clear_done_d;
      lines_last_q  <= lines_last_d;
      lines_total_q <= lines_total_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
    end
  end

  assign rd_cell     = rd_cell_q;
  assign busy        = (state_q != StIdle);
  assign clear_done  = clear_done_q;
  assign lines_last  = lines_last_q;
  assign lines_total = lines_total_q;
  assign score       = score_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_board_lock_clear.sv
// Bench for board_lock_clear: directed lock sequences plus random locks, checked
// against a row-removal reference model through a scoreboard of per-lock results.
module tb_board_lock_clear;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       lock_en = 1'b0;
  logic [4:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [4:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0;
  logic [4:0] block = 5'b10000;
  logic [4:0] rd_row = '0, rd_col = '0;
  logic [2:0] rd_cell;
  logic       busy, clear_done, game_over;
  logic [2:0] lines_last;
  logic [7:0] lines_total;
  logic [15:0] score;

  board_lock_clear dut (
    .pclk(pclk), .rst(rst), .lock_en(lock_en),
    .sq_1_col(c1), .sq_2_col(c2), .sq_3_col(c3), .sq_4_col(c4),
    .sq_1_row(r1), .sq_2_row(r2), .sq_3_row(r3), .sq_4_row(r4),
    .block(block), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .busy(busy), .clear_done(clear_done), .lines_last(lines_last),
    .lines_total(lines_total), .score(score), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int ll;
    int lt;
    int sc;
    int go;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mb [20][10];
  int   m_total, m_score, m_go;
  int   sc_c [4];
  int   sc_r [4];

  task automatic model_reset();
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) mb[r][c] = 0;
    m_total = 0;
    m_score = 0;
    m_go    = 0;
  endtask

  // Lock the piece, then drop every full row and let the rest fall together.
  task automatic model_lock(input int blk);
    int   tmp [20][10];
    int   colr, cnt, cyc, dst, add;
    bit   full;
    exp_t e;
    colr = (blk & 7) + 1;
    for (int k = 0; k < 4; k++) begin
      if (sc_c[k] < 10 && sc_r[k] < 20) begin
        mb[sc_r[k]][sc_c[k]] = colr;
        if (sc_r[k] == 0) m_go = 1;
      end
    end
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) tmp[r][c] = 0;
    cnt = 0;
    cyc = 22;
    dst = 19;
    for (int i = 19; i >= 0; i--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++) if (mb[i][c] == 0) full = 1'b0;
      if (full) begin
        // Row sits at i+cnt when found: shift of that many+1 rows plus one rescan.
        cyc += i + cnt + 2;
        cnt++;
      end else begin
        for (int c = 0; c < 10; c++) tmp[dst][c] = mb[i][c];
        dst--;
      end
    end
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) mb[r][c] = tmp[r][c];
    case (cnt)
      1: add = 40;
      2: add = 100;
      3: add = 300;
      4: add = 1200;
      default: add = 0;
    endcase
    m_score = (m_score + add > 65535) ? 65535 : m_score + add;
    m_total = (m_total + cnt > 255) ? 255 : m_total + cnt;
    e.ll  = cnt;
    e.lt  = m_total;
    e.sc  = m_score;
    e.go  = m_go;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge pclk);
      if (!rst) begin
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (clear_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_clear_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("lines_last", int'(lines_last), e.ll);
            check("lines_total", int'(lines_total), e.lt);
            check("score", int'(score), e.sc);
            check("game_over", int'(game_over), e.go);
            check("busy_cycles", bcnt, e.cyc);
          end
          bcnt = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic lock_start(input int a1, input int b1, input int a2, input int b2,
                            input int a3, input int b3, input int a4, input int b4,
                            input int blk);
    sc_c[0] = a1; sc_r[0] = b1; sc_c[1] = a2; sc_r[1] = b2;
    sc_c[2] = a3; sc_r[2] = b3; sc_c[3] = a4; sc_r[3] = b4;
    c1 = 5'(a1); r1 = 5'(b1); c2 = 5'(a2); r2 = 5'(b2);
    c3 = 5'(a3); r3 = 5'(b3); c4 = 5'(a4); r4 = 5'(b4);
    block = 5'(blk);
    lock_en = 1'b1;
    model_lock(blk);
    @(negedge pclk);
    lock_en = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge pclk);
      t++;
    end
    if (t >= 300) check("idle_timeout", int'(busy), 0);
  endtask

  task automatic lock(input int a1, input int b1, input int a2, input int b2,
                      input int a3, input int b3, input int a4, input int b4,
                      input int blk);
    lock_start(a1, b1, a2, b2, a3, b3, a4, b4, blk);
    wait_idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_clear_done"}, int'(clear_done), 0);
    check({tag, "_lines_last"}, int'(lines_last), 0);
    check({tag, "_lines_total"}, int'(lines_total), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_rd_cell"}, int'(rd_cell), 0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    #2 rst = 1'b0;
    model_reset();
    exp_q.delete();
    #1 check_outputs_zero("reset");
    @(negedge pclk);
    rst = 1'b1;
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        rd_row = 5'(r);
        rd_col = 5'(c);
        @(negedge pclk);
        check($sformatf("%s_cell[%0d][%0d]", tag, r, c), int'(rd_cell), mb[r][c]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 check_outputs_zero("por");
    repeat (2) @(negedge pclk);
    rst = 1'b1;

    // O piece, no clear
    lock(4, 18, 5, 18, 4, 19, 5, 19, 5'b10001);
    check_board("t1");

    // single line with row 18 content falling into row 19
    do_reset();
    lock(0, 19, 1, 19, 2, 19, 3, 19, 5'b10011);
    lock(4, 19, 5, 19, 8, 19, 9, 19, 5'b10100);
    lock(6, 19, 7, 19, 6, 18, 7, 18, 5'b10000);
    check_board("t2");

    // four lines at once
    do_reset();
    for (int r = 16; r < 20; r++) begin
      lock(0, r, 1, r, 2, r, 3, r, 5'b10010);
      lock(4, r, 5, r, 6, r, 7, r, 5'b10101);
      lock(8, r, 8, r, 8, r, 8, r, 5'b10110);
    end
    lock(9, 16, 9, 17, 9, 18, 9, 19, 5'b10000);
    check("t3_score", int'(score), 1200);
    check_board("t3");

    // non-adjacent full rows 17 and 19
    do_reset();
    for (int r = 17; r < 20; r += 2) begin
      lock(0, r, 1, r, 2, r, 3, r, 5'b10001);
      lock(4, r, 5, r, 6, r, 7, r, 5'b10011);
      lock(8, r, 8, r, 8, r, 8, r, 5'b10100);
    end
    lock(0, 18, 1, 18, 2, 18, 2, 18, 5'b10110);
    lock(9, 17, 9, 18, 9, 19, 9, 19, 5'b10000);
    check_board("t4");

    // game over, sticky; col 12 skipped
    do_reset();
    lock(3, 0, 12, 5, 4, 1, 4, 2, 5'b10010);
    lock(0, 19, 1, 19, 0, 18, 1, 18, 5'b10001);
    check("t5_game_over_sticky", int'(game_over), 1);
    rd_row = 5'd5;
    rd_col = 5'd12;
    @(negedge pclk);
    check("t5_rd_out_of_range", int'(rd_cell), 0);
    check_board("t5");

    // lock while busy ignored, then reset in the middle of a shift
    do_reset();
    lock(0, 19, 1, 19, 2, 19, 3, 19, 5'b10011);
    lock(4, 19, 5, 19, 6, 19, 7, 19, 5'b10011);
    lock_start(8, 19, 9, 19, 0, 18, 1, 18, 5'b10101);
    repeat (3) @(negedge pclk);
    c1 = 5'd0; r1 = 5'd0; c2 = 5'd0; r2 = 5'd0;
    c3 = 5'd0; r3 = 5'd0; c4 = 5'd0; r4 = 5'd0;
    lock_en = 1'b1;
    @(negedge pclk);
    lock_en = 1'b0;
    wait_idle();
    check("t6_ignored_game_over", int'(game_over), 0);
    check_board("t6a");
    lock(2, 19, 3, 19, 0, 10, 1, 10, 5'b10010);
    lock(4, 19, 5, 19, 6, 19, 7, 19, 5'b10010);
    rd_row = 5'd10;
    rd_col = 5'd0;
    lock_start(8, 19, 9, 19, 8, 19, 9, 19, 5'b10010);
    repeat (5) @(negedge pclk);
    check("t6_busy_before_reset", int'(busy), 1);
    check("t6_cell_before_reset", int'(rd_cell != 3'd0), 1);
    check("t6_score_before_reset", int'(score), 40);
    #2 rst = 1'b0;
    model_reset();
    exp_q.delete();
    #1 check_outputs_zero("t6_async");
    @(negedge pclk);
    rst = 1'b1;
    check_board("t6b");

    // random locks
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int cc [4];
      int rr [4];
      for (int k = 0; k < 4; k++) begin
        cc[k] = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 31) : $urandom_range(0, 9);
        case ($urandom_range(0, 39))
          0:       rr[k] = 0;
          1:       rr[k] = $urandom_range(20, 31);
          default: rr[k] = $urandom_range(15, 19);
        endcase
      end
      lock(cc[0], rr[0], cc[1], rr[1], cc[2], rr[2], cc[3], rr[3],
           16 + $urandom_range(0, 6));
      if (i % 20 == 19) check_board($sformatf("rand%0d", i));
    end

    repeat (3) @(negedge pclk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
